// File: rtl/mux_nx1_scan.sv
// N:1 registered multiplexer with manual select and an auto-scan sequencer
// that holds each channel for a programmable dwell time.
module mux_nx1_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [7:0]                dwell,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap
);

  localparam int unsigned DWELL_W = 8;

  // Select-mode states, decoded directly from the mode input.
  localparam logic [0:0] ST_MANUAL = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [0:0]         state_c;
  logic [WIDTH-1:0]   chan_c [CHANNELS];

  logic [WIDTH-1:0]   y_q, y_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic               wrap_q, wrap_d;
  logic [SEL_W-1:0]   chan_q, chan_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  assign state_c = mode ? ST_SCAN : ST_MANUAL;

  // Unpack the flat data bus into per-channel words.
  always_comb begin
    for (int k = 0; k < int'(CHANNELS); k++) begin
      chan_c[k] = d[k*int'(WIDTH) +: WIDTH];
    end
  end

  // Next-state logic: en=0 holds data/counters and drops the strobes.
  always_comb begin
    y_d     = y_q;
    cur_d   = cur_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    chan_d  = chan_q;
    dwell_d = dwell_q;
    if (en) begin
      valid_d = 1'b1;
      case (state_c)
        ST_MANUAL: begin
          y_d     = chan_c[sel_in];
          cur_d   = sel_in;
          chan_d  = '0;
          dwell_d = '0;
        end
        ST_SCAN: begin
          y_d   = chan_c[chan_q];
          cur_d = chan_q;
          // >= so that lowering dwell below the running count advances at once
          if (dwell_q < dwell) begin
            dwell_d = dwell_q + DWELL_W'(1);
          end else begin
            dwell_d = '0;
            chan_d  = chan_q + SEL_W'(1);
            wrap_d  = (chan_q == LAST_CH);
          end
        end
        default: begin
          y_d = y_q;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      cur_q   <= '0;
      wrap_q  <= 1'b0;
      chan_q  <= '0;
      dwell_q <= '0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      cur_q   <= cur_d;
      wrap_q  <= wrap_d;
      chan_q  <= chan_d;
      dwell_q <= dwell_d;
    end
  end

  assign y       = y_q;
  assign y_valid = valid_q;
  assign cur_sel = cur_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed self-checking bench for mux_nx1_scan (WIDTH=8, CHANNELS=4).
module tb_mux_nx1_scan;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned SEL_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [CHANNELS*WIDTH-1:0] d;
  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel_in;
  logic [7:0]                dwell;
  logic [WIDTH-1:0]          y;
  logic                      y_valid;
  logic [SEL_W-1:0]          cur_sel;
  logic                      wrap;

  int checks;
  int failures;

  logic [7:0] vals [4];

  mux_nx1_scan #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (d),
    .en      (en),
    .mode    (mode),
    .sel_in  (sel_in),
    .dwell   (dwell),
    .y       (y),
    .y_valid (y_valid),
    .cur_sel (cur_sel),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] ey, input logic ev,
                            input logic [1:0] ec, input logic ew);
    check({tag, ".y"},       32'(y),       32'(ey));
    check({tag, ".y_valid"}, 32'(y_valid), 32'(ev));
    check({tag, ".cur_sel"}, 32'(cur_sel), 32'(ec));
    check({tag, ".wrap"},    32'(wrap),    32'(ew));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vals[0] = 8'hAA; vals[1] = 8'hBB; vals[2] = 8'hCC; vals[3] = 8'hDD;

    // Reset held for two cycles with random data and en=1.
    rst_n  = 1'b0;
    en     = 1'b1;
    mode   = 1'b0;
    sel_in = 2'd1;
    dwell  = 8'd0;
    d      = $urandom();
    for (int i = 0; i < 2; i++) begin
      step();
      expect_out("reset", 8'h00, 1'b0, 2'd0, 1'b0);
      d = $urandom();
    end

    // Manual selection of each channel.
    d     = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel_in = 2'(i);
      step();
      expect_out("manual", vals[i], 1'b1, 2'(i), 1'b0);
    end

    // Auto-scan, dwell=0: wrap pulses with the last channel's sample.
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_out("scan_d0", vals[i % 4], 1'b1, 2'(i % 4), (i % 4) == 3);
    end

    // Auto-scan, dwell=2: three cycles per channel.
    dwell = 8'd2;
    for (int i = 0; i < 12; i++) begin
      step();
      expect_out("scan_d2", vals[i / 3], 1'b1, 2'(i / 3), i == 11);
    end

    // Freeze mid-BB, then resume with the remaining BB holds.
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("pre_freeze", vals[i / 3], 1'b1, 2'(i / 3), 1'b0);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("frozen", 8'hBB, 1'b0, 2'd1, 1'b0);
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("resume", (i < 2) ? 8'hBB : 8'hCC, 1'b1, (i < 2) ? 2'd1 : 2'd2, 1'b0);
    end

    // Auto->manual takes effect immediately, then auto restarts at channel 0.
    mode   = 1'b0;
    sel_in = 2'd2;
    step();
    expect_out("to_manual", 8'hCC, 1'b1, 2'd2, 1'b0);
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("to_auto", vals[i / 3], 1'b1, 2'(i / 3), 1'b0);
    end

    // Lowering dwell below the running count advances on the next cycle.
    dwell = 8'd0;
    step();
    expect_out("dwell_drop", 8'hBB, 1'b1, 2'd1, 1'b0);
    step();
    expect_out("dwell_drop2", 8'hCC, 1'b1, 2'd2, 1'b0);

    // Reset while channel 3 is active, then restart from channel 0.
    rst_n = 1'b0;
    step();
    expect_out("mid_reset", 8'h00, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("post_reset", vals[i], 1'b1, 2'(i), i == 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
